// File: rtl/uart_boot_loader_pkg.sv
// Shared constants for the UART boot loader: frame bytes, loader FSM
// encodings and receiver FSM encodings.
package uart_boot_loader_pkg;

    // Framing of a boot image
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         LEN_W          = 16;

    // Loader FSM encodings
    localparam logic [2:0] ST_SYNC   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERROR  = 3'd6;

    // Byte receiver FSM encodings
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// 8N1 UART byte receiver: two-flop synchronizer, falling-edge start
// detection with a mid-bit re-check, LSB-first deserializer and stop check.
module uart_rx_core #(
    parameter int BIT_CYC = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);
    import uart_boot_loader_pkg::*;

    localparam int               CNT_W   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    assign byte_data = shreg;

    // Bring the asynchronous line into the clock domain; idle level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit timing and deserialization; a start bit that is high again at mid-bit is dropped as a glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'd0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt      <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt      <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                        end else begin
                            stop_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an image (A5, 16-bit word count, words,
// XOR checksum), writes it into the instruction ROM and releases the
// CPU reset once the checksum has matched.
module uart_boot_loader #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ROM_AW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              frame_err
);
    import uart_boot_loader_pkg::*;

    localparam int          BIT_CYC   = CLK_FREQ / BAUD;
    localparam logic [16:0] MAX_WORDS = 17'd1 << ROM_AW;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             stop_err;

    logic [2:0]       state;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] n_words;
    logic [LEN_W-1:0] word_cnt;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
    logic [7:0]       csum;
    logic [LEN_W-1:0] len_full;

    assign len_full = {byte_data, len_lo};

    // The core stays in reset until an image has been verified
    assign cpu_rst   = (state != ST_DONE);
    assign load_done = (state == ST_DONE);
    assign frame_err = (state == ST_ERROR);

    uart_rx_core #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .stop_err   (stop_err)
    );

    // Image parser: sync search, length, word assembly with ROM writes, checksum verdict
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SYNC;
            len_lo    <= 8'd0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_idx  <= 2'd0;
            word_buf  <= 24'd0;
            csum      <= 8'd0;
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= 32'd0;
        end else begin
            rom_we <= 1'b0;
            if (rom_we && state == ST_DATA) begin
                rom_waddr <= rom_waddr + ROM_AW'(1);
            end
            if (stop_err && state != ST_DONE) begin
                state <= ST_ERROR;
            end else if (byte_valid) begin
                case (state)
                    ST_SYNC, ST_ERROR: begin
                        if (byte_data == SYNC_BYTE) begin
                            state     <= ST_LEN_LO;
                            rom_waddr <= '0;
                            word_cnt  <= '0;
                            byte_idx  <= 2'd0;
                            csum      <= 8'd0;
                        end
                    end
                    ST_LEN_LO: begin
                        len_lo <= byte_data;
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        n_words <= len_full;
                        if (len_full == '0) begin
                            state <= ST_CSUM;
                        end else if ({1'b0, len_full} > MAX_WORDS) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        csum <= csum ^ byte_data;
                        if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                            byte_idx  <= 2'd0;
                            rom_we    <= 1'b1;
                            rom_wdata <= {byte_data, word_buf};
                            word_cnt  <= word_cnt + LEN_W'(1);
                            if (word_cnt + LEN_W'(1) == n_words) begin
                                state <= ST_CSUM;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            word_buf <= {byte_data, word_buf[23:8]};
                        end
                    end
                    ST_CSUM: begin
                        if (byte_data == csum) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_ERROR;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_DONE;
                    end
                    default: state <= ST_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for the UART boot loader: a stream-level image parser
// predicts ROM writes and the final verdict; a monitor checks every write.
module tb_uart_boot_loader;

    localparam int CLK_FREQ = 2400000;
    localparam int BAUD     = 100000;
    localparam int ROM_AW   = 12;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;

    typedef logic [7:0] byteq_t[$];
    typedef logic [31:0] wordq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              uart_rx = 1'b1;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              frame_err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    int          model_outcome = 0;
    bit          model_done = 0;

    uart_boot_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ROM_AW   (ROM_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Reference parser over a byte stream: 0 = loading/idle, 1 = done, 2 = error
    task automatic model_stream(input byteq_t s);
        int i;
        int n;
        logic [7:0] cs;
        bit complete;
        i = 0;
        if (model_done) return;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            model_outcome = 0;
            if (i + 2 > s.size()) break;
            n = int'(s[i]) + 256 * int'(s[i+1]);
            i += 2;
            if (n > (1 << ROM_AW)) begin
                model_outcome = 2;
                continue;
            end
            cs = 8'd0;
            complete = 1;
            for (int k = 0; k < n && complete; k++) begin
                if (i + 4 > s.size()) begin
                    complete = 0;
                end else begin
                    exp_addr_q.push_back(32'(k));
                    exp_data_q.push_back({s[i+3], s[i+2], s[i+1], s[i]});
                    cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                    i += 4;
                end
            end
            if (!complete || i >= s.size()) break;
            if (s[i] == cs) begin
                model_outcome = 1;
                model_done = 1;
                break;
            end
            model_outcome = 2;
            i++;
        end
    endtask

    function automatic byteq_t build_image(input wordq_t words, input bit corrupt);
        byteq_t q;
        logic [7:0] cs;
        cs = 8'd0;
        q.push_back(8'hA5);
        q.push_back(8'(words.size()));
        q.push_back(8'(words.size() >> 8));
        foreach (words[k]) begin
            for (int b = 0; b < 4; b++) begin
                q.push_back(words[k][8*b +: 8]);
                cs = cs ^ words[k][8*b +: 8];
            end
        end
        q.push_back(corrupt ? (cs ^ 8'h01) : cs);
        return q;
    endfunction

    // Serialize one 8N1 byte, optionally with the stop bit held low
    task automatic applyStimulus(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rx = bad_stop ? 1'b0 : 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_seq(input byteq_t s);
        foreach (s[k]) applyStimulus(s[k], 1'b0);
    endtask

    task automatic send_glitch();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CYC / 2 - 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic check_end(input string name);
        repeat (4) @(negedge clk);
        checkOutput({name, " writes_left"}, 32'(exp_addr_q.size()), 32'd0);
        checkOutput({name, " load_done"}, 32'(load_done), 32'(model_outcome == 1));
        checkOutput({name, " cpu_rst"}, 32'(cpu_rst), 32'(model_outcome != 1));
        checkOutput({name, " frame_err"}, 32'(frame_err), 32'(model_outcome == 2));
    endtask

    task automatic run_image(input string name, input byteq_t s);
        model_stream(s);
        send_seq(s);
        check_end(name);
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, " rom_we"}, 32'(rom_we), 32'd0);
        checkOutput({name, " rom_waddr"}, 32'(rom_waddr), 32'd0);
        checkOutput({name, " rom_wdata"}, rom_wdata, 32'd0);
        checkOutput({name, " cpu_rst"}, 32'(cpu_rst), 32'd1);
        checkOutput({name, " load_done"}, 32'(load_done), 32'd0);
        checkOutput({name, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        model_outcome = 0;
        model_done = 0;
        repeat (3) @(negedge clk);
        check_reset_values(name);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every ROM write must match the oldest predicted write
    always @(negedge clk) begin
        if (rst && rom_we) begin
            if (exp_addr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", rom_waddr, rom_wdata);
            end else begin
                exp_a = exp_addr_q.pop_front();
                exp_d = exp_data_q.pop_front();
                checkOutput("write_addr", 32'(rom_waddr), exp_a);
                checkOutput("write_data", rom_wdata, exp_d);
            end
        end
    end

    initial begin
        byteq_t s;
        wordq_t w;
        logic [7:0] b;

        do_reset("reset");

        // Reference two-word load
        w = '{32'h00000093, 32'h00100113};
        run_image("full_load", build_image(w, 1'b0));

        // Bad checksum, then the correct image recovers from ERROR
        do_reset("reset2");
        s = build_image(w, 1'b0);
        s[s.size()-1] = 8'h81;
        run_image("csum_err", s);
        run_image("csum_retry", build_image(w, 1'b0));

        // Stop bit low on the third data byte
        do_reset("reset3");
        s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        model_stream(s);
        send_seq(s);
        applyStimulus(8'h33, 1'b1);
        model_outcome = 2;
        send_seq('{8'h44, 8'h55});
        check_end("frame_err");
        run_image("frame_recover", build_image(w, 1'b0));

        // Noise before an empty image; traffic after DONE is ignored
        do_reset("reset4");
        run_image("empty_image", '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
        run_image("after_done", build_image(w, 1'b0));

        // Oversize count, then a glitch inside a valid load
        do_reset("reset5");
        run_image("oversize", '{8'hA5, 8'h01, 8'h10});
        s = build_image('{32'hCAFEF00D}, 1'b0);
        model_stream(s);
        applyStimulus(s[0], 1'b0);
        send_glitch();
        s.pop_front();
        send_seq(s);
        check_end("glitch");

        // Largest legal count is accepted (load left pending)
        do_reset("reset6");
        run_image("max_count", '{8'hA5, 8'h00, 8'h10});

        // Reset in the middle of a load
        do_reset("reset7");
        s = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        run_image("mid_load", s);
        @(negedge clk);
        #3 rst = 1'b0;
        #1 check_reset_values("async_reset");
        do_reset("reset8");

        // Randomized images with leading noise and occasional checksum corruption
        for (int it = 0; it < 5; it++) begin
            do_reset("reset_rand");
            s.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                b = 8'($urandom_range(0, 255));
                s.push_back((b == 8'hA5) ? 8'h5A : b);
            end
            w.delete();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) w.push_back($urandom);
            s = {s, build_image(w, ($urandom_range(0, 2) == 0))};
            run_image("random", s);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
